fifo_stream_reader: RTL and testbench

Read-side companion of the asynchronous FIFO: runs entirely in the FIFO read-clock domain, drives the FIFO's `rd_en`, captures its one-cycle-late `data_out`, and presents the words to the convolution datapath as a valid/ready stream. It sustains 1 word/cycle, absorbs downstream back-pressure with a 2-entry buffer, and tags every LINE_LEN-th word with `m_last`, marking the end of an image line.

---
 rtl/conv_stream_pkg.sv | 19 +
 rtl/fifo_stream_reader_if.sv | 26 ++
 rtl/stream_buf2.sv | 53 +++++
 rtl/fifo_stream_reader.sv | 73 +++++++
 tb/tb_fifo_stream_reader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_stream_pkg.sv
// Shared types and sizing helpers for the convolution stream path.
// The stream-beat struct is the common word format of all conv stages.
package conv_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_LINE_LEN   = 16;
    localparam int BEAT_W = (DEFAULT_LINE_LEN > 1) ? $clog2(DEFAULT_LINE_LEN) : 1;

    // Beat-counter width for an arbitrary line length; one bit minimum so LINE_LEN=1 still works.
    function automatic int beat_w(input int line_len);
        return (line_len > 1) ? $clog2(line_len) : 1;
    endfunction

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic                          last;
    } stream_beat_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream, seen from the reader (master)
// and from the surrounding FIFO/sink (slave).
interface fifo_stream_reader_if
    import conv_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic [1:0]            level;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last, level
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last, level
    );
endinterface

// File: rtl/stream_buf2.sv
// Two-entry register buffer: push at the tail, pop from the head, both allowed in one cycle.
// Callers guarantee no push when full and no pop when empty.
module stream_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_level
);
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic [1:0]            r_level;

    // NOTE: the storage is reset too because the head drives m_data, which must read 0 out of reset;
    // all state here uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_level  <= 2'd0;
        end else if (i_clear) begin
            r_level <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    r_mem[r_level[0]] <= i_data;
                    r_level           <= r_level + 2'd1;
                end
                2'b01: begin
                    r_mem[0] <= r_mem[1];
                    r_level  <= r_level - 2'd1;
                end
                2'b11: begin
                    if (r_level == 2'd1) begin
                        r_mem[0] <= i_data;
                    end else begin
                        r_mem[0] <= r_mem[1];
                        r_mem[1] <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[0];
    assign o_level = r_level;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO companion: credit-based rd_en, one-cycle-late capture into a 2-entry
// buffer, valid/ready output stream with an end-of-line marker every LINE_LEN beats.
module fifo_stream_reader
    import conv_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LINE_LEN   = DEFAULT_LINE_LEN
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    input  logic                 flush,
    fifo_stream_reader_if.master bus
);
    localparam int              LINE_BEAT_W = beat_w(LINE_LEN);
    localparam [LINE_BEAT_W-1:0] LAST_BEAT  = LINE_BEAT_W'(LINE_LEN - 1);

    logic                   r_inflight;
    logic                   r_discard;
    logic [LINE_BEAT_W-1:0] r_beat_cnt;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_en;
    logic [1:0]            w_level;
    logic [2:0]            w_credit;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_valid = (w_level != 2'd0);
    assign w_pop   = w_valid && bus.m_ready;

    // Words already owned (buffered + in flight) after this cycle's pop; a read is only
    // issued when its word is guaranteed a slot, so the buffer can never overflow.
    assign w_credit = {1'b0, w_level} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en  = rst_n && !flush && !bus.fifo_empty && (w_credit < 3'd2);
    assign w_push   = r_inflight && !r_discard;

    stream_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk    (rd_clk),
        .rst_n  (rst_n),
        .i_clear(flush),
        .i_push (w_push),
        .i_data (bus.fifo_data),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_level(w_level)
    );

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_inflight <= w_rd_en;
            r_discard  <= flush ? r_inflight : 1'b0;
            if (flush) begin
                r_beat_cnt <= '0;
            end else if (w_pop) begin
                r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_head;
    assign bus.m_last     = w_valid && (r_beat_cnt == LAST_BEAT);
    assign bus.level      = w_level;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO in front, expected-word lists behind,
// one task per scenario; stimulus applied after the falling edge, outputs sampled 1 time unit later.
module tb_fifo_stream_reader;
    import conv_stream_pkg::*;

    localparam int DW = 8;
    localparam int LL = 16;

    logic rd_clk  = 1'b0;
    logic rst_n   = 1'b0;
    logic flush   = 1'b0;
    logic m_ready = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .LINE_LEN(LL)) dut (
        .rd_clk(rd_clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // Behavioural FIFO: data_out valid the cycle after an accepted read; cleared by rst_n.
    logic [DW-1:0] fifo_mem [0:4095];
    logic [DW-1:0] fifo_data_q = '0;
    int            wr_ptr      = 0;
    int            rd_ptr      = 0;
    int            fifo_reads  = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_data  = fifo_data_q;
    assign bus.m_ready    = m_ready;

    always @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= wr_ptr;
            fifo_reads  <= 0;
            fifo_data_q <= '0;
        end else if (bus.fifo_rd_en) begin
            fifo_data_q <= fifo_mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
            fifo_reads  <= fifo_reads + 1;
        end
    end

    task automatic push_word(input logic [DW-1:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr++;
    endtask

    task automatic apply_reset();
        @(negedge rd_clk);
        rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge rd_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.m_data); end
        n_checks++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", bus.m_last); end
        n_checks++; if (bus.level !== 2'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        @(negedge rd_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_rate();
        stream_beat_t exp_b, got_b;
        apply_reset();
        for (int i = 1; i <= 32; i++) push_word(8'(i));
        m_ready = 1'b1;
        for (int c = 0; c < 37; c++) begin
            if (c > 0) @(negedge rd_clk);
            #1;
            if (c < 2) begin
                n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL full_rd_en c%0d: got %b want 1", c, bus.fifo_rd_en); end
                n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL full_latency c%0d: got %b want 0", c, bus.m_valid); end
            end else if (c < 34) begin
                exp_b.data = 8'(c - 1);
                exp_b.last = ((c - 2) % LL) == (LL - 1);
                got_b = '{data: bus.m_data, last: bus.m_last};
                n_checks++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL full_bubble c%0d: got %b want 1", c, bus.m_valid); end
                n_checks++; if (got_b !== exp_b) begin n_fail++; $display("FAIL full_beat c%0d: got %h/%b want %h/%b", c, got_b.data, got_b.last, exp_b.data, exp_b.last); end
            end else begin
                n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL full_extra c%0d: got %b want 0", c, bus.m_valid); end
            end
        end
    endtask

    task automatic test_back_pressure();
        int k;
        apply_reset();
        for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge rd_clk);
            #1;
            n_checks++; if (fifo_reads > 2) begin n_fail++; $display("FAIL bp_pulled c%0d: got %0d want <=2", c, fifo_reads); end
            if (c >= 2) begin
                n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en c%0d: got %b want 0", c, bus.fifo_rd_en); end
                n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA0) begin n_fail++; $display("FAIL bp_hold c%0d: got %b/%h want 1/a0", c, bus.m_valid, bus.m_data); end
            end
            if (c >= 3) begin
                n_checks++; if (bus.level !== 2'd2) begin n_fail++; $display("FAIL bp_level c%0d: got %0d want 2", c, bus.level); end
            end
        end
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge rd_clk);
            m_ready = 1'b1;
            #1;
            if (bus.m_valid === 1'b1) begin
                n_checks++; if (bus.m_data !== 8'hA0 + 8'(k)) begin n_fail++; $display("FAIL bp_drain k%0d: got %h want %h", k, bus.m_data, 8'hA0 + 8'(k)); end
                k++;
            end
        end
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", k); end
        repeat (4) begin
            @(negedge rd_clk); #1;
            n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup: got %b want 0", bus.m_valid); end
        end
    endtask

    task automatic test_random();
        stream_beat_t exp_q [$];
        stream_beat_t exp_b, got_b;
        int k, cyc;
        apply_reset();
        for (int i = 0; i < 1000; i++) begin
            exp_b.data = 8'($urandom);
            exp_b.last = (i % LL) == (LL - 1);
            exp_q.push_back(exp_b);
            push_word(exp_b.data);
        end
        k = 0; cyc = 0;
        while (k < 1000 && cyc < 8000) begin
            @(negedge rd_clk);
            m_ready = 1'($urandom % 2);
            #1;
            cyc++;
            n_checks++; if (fifo_reads - k > 2) begin n_fail++; $display("FAIL rnd_owned cyc%0d: got %0d want <=2", cyc, fifo_reads - k); end
            if (bus.m_valid === 1'b1 && m_ready) begin
                got_b = '{data: bus.m_data, last: bus.m_last};
                n_checks++; if (got_b !== exp_q[k]) begin n_fail++; $display("FAIL rnd_beat k%0d: got %h/%b want %h/%b", k, got_b.data, got_b.last, exp_q[k].data, exp_q[k].last); end
                k++;
            end
        end
        n_checks++; if (k != 1000) begin n_fail++; $display("FAIL rnd_count: got %0d want 1000", k); end
        m_ready = 1'b0;
    endtask

    task automatic test_flush();
        int k;
        apply_reset();
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
        m_ready = 1'b1;
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL flush_first_rd: got %b want 1", bus.fifo_rd_en); end
        @(negedge rd_clk);
        flush = 1'b1;
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_rd_en: got %b want 0", bus.fifo_rd_en); end
        @(negedge rd_clk);
        flush = 1'b0;
        for (int i = 0; i < 13; i++) push_word(8'h15 + 8'(i));
        #1;
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b want 0", bus.m_valid); end
        k = 0;
        for (int c = 0; c < 60 && k < 16; c++) begin
            @(negedge rd_clk); #1;
            if (bus.m_valid === 1'b1) begin
                n_checks++; if (bus.m_data !== 8'h12 + 8'(k) || bus.m_last !== (k == LL - 1)) begin n_fail++; $display("FAIL flush_beat k%0d: got %h/%b want %h/%b", k, bus.m_data, bus.m_last, 8'h12 + 8'(k), k == LL - 1); end
                k++;
            end
        end
        n_checks++; if (k != 16) begin n_fail++; $display("FAIL flush_count: got %0d want 16", k); end
    endtask

    task automatic test_empty();
        apply_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge rd_clk); #1;
            n_checks++; if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_idle c%0d: got %b/%b want 0/0", c, bus.fifo_rd_en, bus.m_valid); end
        end
        @(negedge rd_clk);
        push_word(8'h5A);
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL empty_rd: got %b want 1", bus.fifo_rd_en); end
        @(negedge rd_clk); #1;
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_early: got %b want 0", bus.m_valid); end
        @(negedge rd_clk); #1;
        n_checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h5A) begin n_fail++; $display("FAIL empty_word: got %b/%h want 1/5a", bus.m_valid, bus.m_data); end
        @(negedge rd_clk); #1;
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_after: got %b want 0", bus.m_valid); end
    endtask

    task automatic test_async_reset();
        int k;
        apply_reset();
        for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
        m_ready = 1'b0;
        repeat (4) @(negedge rd_clk);
        #1;
        n_checks++; if (bus.level !== 2'd2) begin n_fail++; $display("FAIL arst_pre_level: got %0d want 2", bus.level); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_last !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl: got %b/%b/%b want 0/0/0", bus.fifo_rd_en, bus.m_valid, bus.m_last); end
        n_checks++; if (bus.m_data !== 8'h00 || bus.level !== 2'd0) begin n_fail++; $display("FAIL arst_state: got %h/%0d want 00/0", bus.m_data, bus.level); end
        @(negedge rd_clk);
        @(negedge rd_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
        m_ready = 1'b1;
        #1;
        n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale: got %b want 0", bus.m_valid); end
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge rd_clk); #1;
            if (bus.m_valid === 1'b1) begin
                n_checks++; if (bus.m_data !== 8'h40 + 8'(k) || k >= 4) begin n_fail++; $display("FAIL arst_refill k%0d: got %h want %h", k, bus.m_data, 8'h40 + 8'(k)); end
                k++;
            end
        end
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL arst_count: got %0d want 4", k); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_rate();
        test_back_pressure();
        test_random();
        test_flush();
        test_empty();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
